imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parametrised immediate generator for the FemtoRV32 decode path. It accepts a 32-bit instruction plus an opaque tag over a valid/ready handshake. It returns the XLEN-wide extended immediate, an immediate-format code and an illegal-opcode flag one cycle later. A two-entry skid buffer registers `in_ready`, so decode can be retimed without combinational ready paths. Shift-immediate and RV64 handling are correct per the RISC-V base ISA.

## Interface
- `XLEN`, 32: immediate width; legal values 32 or 64.
- `TAG_W`, 32: width of the pass-through tag (typically the PC).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  block can accept; registered.
- `in_inst`  in  32  raw instruction.
- `in_tag`  in  TAG_W  passed through unchanged.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts.
- `out_imm`  out  XLEN  extended immediate.
- `out_fmt`  out  3  format code `imm_fmt_t`.
- `out_illegal`  out  1  unknown opcode, or `inst[1:0]` != 2'b11.
- `out_tag`  out  TAG_W  tag of this result.

## Operation
- A transfer occurs on a rising edge when valid and ready are both 1, on either side.
- Decode is on `inst[6:0]`. Here i = `in_inst` and s = sign fill from i[31].
- I (LOAD 0000011, JALR 1100111, OP-IMM 0010011): {s, i[31:20]}.
- Shift exception for OP-IMM with funct3 001 or 101: zero-extended shamt. Use i[24:20] for XLEN=32 and i[25:20] for XLEN=64. `fmt` = SHAMT.
- S (0100011): {s, i[31:25], i[11:7]}.
- B (1100011): {s, i[31], i[7], i[30:25], i[11:8], 1'b0}.
- U (LUI 0110111, AUIPC 0010111): {s, i[31:12], 12'b0}. The fill applies only when XLEN=64.
- J (1101111): {s, i[31], i[19:12], i[20], i[30:21], 1'b0}.
- OP-IMM-32 (0011011): I/SHAMT rules with a 5-bit shamt. It is legal only when XLEN=64; when XLEN=32 it is illegal.
- No-immediate opcodes (OP 0110011, OP-32 when XLEN=64, FENCE 0001111, SYSTEM 1110011): imm 0, fmt NONE, illegal 0.
- Any other opcode: imm 0, fmt NONE, illegal 1.
- FSM states: EMPTY, ONE (output register full), TWO (output register and skid register full).
  - EMPTY: an accept loads the output register and moves to ONE.
  - ONE: accept without drain reloads nothing and moves to TWO, with the new entry in skid. Drain without accept moves to EMPTY. Accept with drain loads the output register and stays in ONE.
  - TWO: no accept is possible. A drain moves skid into the output register and goes to ONE.
- `in_ready` = (next state != TWO), registered.
- `out_valid` = (state != EMPTY).
- Ordering is strict FIFO; no entry is dropped or duplicated.

## Timing
- Latency: an instruction accepted at edge N is presented at out_* after edge N (one cycle) when the block is EMPTY or draining.
- Throughput: one result per cycle while `out_ready` = 1.
- `out_*` hold stable while `out_valid` = 1 and `out_ready` = 0.
- Reset values, asynchronous: state EMPTY, `in_ready` 1, `out_valid` 0, `out_imm` 0, `out_fmt` NONE, `out_illegal` 0, `out_tag` 0.
- Reset asserted mid-operation discards both entries immediately. The first accept is possible on the first edge after deassertion.
- Changes to `in_*` while `in_ready` = 0 are ignored.

## Configuration
- `IMM_GEN_ZICSR_EN` defined: SYSTEM with funct3[2] = 1 (CSRRWI/CSRRSI/CSRRCI) yields zimm {0, i[19:15]}, `fmt` = CSRI. Other SYSTEM encodings stay NONE.
- `IMM_GEN_ZICSR_EN` undefined: all SYSTEM encodings yield imm 0, fmt NONE, illegal 0.

## Structure
- Package `imm_gen_pkg` holds:
  - `imm_fmt_t` (NONE=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6, CSRI=7);
  - opcode localparams;
  - a function `imm_decode(inst)` returning {imm, fmt, illegal}.
- Sub-module `imm_skid_buf`, parametrised on payload width, implements the EMPTY/ONE/TWO handshake. The top level is the decode function plus this buffer.

## Test plan
- XLEN=32, LUI 0x800000B7 -> imm 0x80000000, fmt U. XLEN=64, same instruction -> 0xFFFFFFFF80000000.
- JAL x1,-4 (0xFFDFF0EF) -> imm 0xFFFFFFFC, fmt J. SRAI x1,x1,3 (0x4030D093) -> imm 3, fmt SHAMT.
- Back-to-back stream of 8 instructions with `out_ready` low for 3 cycles mid-stream:
  - `in_ready` falls exactly when the second entry is captured;
  - all 8 results emerge in order with matching tags.
- Opcode 0x7F and instruction 0x00000000 -> illegal 1, imm 0. XLEN=32 with opcode 0011011 -> illegal 1.
- Reset asserted while in state TWO -> `out_valid` 0 and `in_ready` 1 without waiting for a clock edge; no stale result after release.
- With `IMM_GEN_ZICSR_EN` defined, CSRRWI x0,mstatus,31 (0x300FD073) -> imm 31, fmt CSRI. With the macro undefined -> imm 0, fmt NONE.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared types, opcode constants and the combinational immediate decoder for imm_gen_pipe.
// Build option: IMM_GEN_ZICSR_EN enables zimm extraction for CSR*I instructions.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_J     = 3'd5,
    IMM_SHAMT = 3'd6,
    IMM_CSRI  = 3'd7
  } imm_fmt_t;

  typedef struct packed {
    logic [63:0] imm;
    imm_fmt_t    fmt;
    logic        illegal;
  } imm_dec_t;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_FENCE     = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // The immediate is always built 64 bits wide; callers keep the low XLEN bits.
  function automatic imm_dec_t imm_decode(input logic [31:0] inst, input logic rv64);
    imm_dec_t    d;
    logic [63:0] s;
    logic [2:0]  f3;
    logic        is_shift;
    s        = {64{inst[31]}};
    f3       = inst[14:12];
    is_shift = (f3 == 3'b001) || (f3 == 3'b101);
    d.imm     = '0;
    d.fmt     = IMM_NONE;
    d.illegal = 1'b0;
    if (inst[1:0] != 2'b11) begin
      d.illegal = 1'b1;
    end else begin
      case (inst[6:0])
        OPC_LOAD, OPC_JALR: begin
          d.imm = {s[63:12], inst[31:20]};
          d.fmt = IMM_I;
        end
        OPC_OP_IMM: begin
          if (is_shift) begin
            d.imm = rv64 ? {58'b0, inst[25:20]} : {59'b0, inst[24:20]};
            d.fmt = IMM_SHAMT;
          end else begin
            d.imm = {s[63:12], inst[31:20]};
            d.fmt = IMM_I;
          end
        end
        OPC_OP_IMM_32: begin
          if (!rv64) begin
            d.illegal = 1'b1;
          end else if (is_shift) begin
            d.imm = {59'b0, inst[24:20]};
            d.fmt = IMM_SHAMT;
          end else begin
            d.imm = {s[63:12], inst[31:20]};
            d.fmt = IMM_I;
          end
        end
        OPC_STORE: begin
          d.imm = {s[63:12], inst[31:25], inst[11:7]};
          d.fmt = IMM_S;
        end
        OPC_BRANCH: begin
          d.imm = {s[63:13], inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
          d.fmt = IMM_B;
        end
        OPC_LUI, OPC_AUIPC: begin
          d.imm = {s[63:32], inst[31:12], 12'b0};
          d.fmt = IMM_U;
        end
        OPC_JAL: begin
          d.imm = {s[63:21], inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
          d.fmt = IMM_J;
        end
        OPC_OP, OPC_FENCE: begin
          d.fmt = IMM_NONE;
        end
        OPC_OP_32: begin
          d.illegal = !rv64;
        end
        OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
          if (f3[2]) begin
            d.imm = {59'b0, inst[19:15]};
            d.fmt = IMM_CSRI;
          end
`else
          d.fmt = IMM_NONE;
`endif
        end
        default: begin
          d.illegal = 1'b1;
        end
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_skid.sv
// Two-entry skid buffer (EMPTY/ONE/TWO) with a registered in_ready and a resettable output register.
module imm_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]   state_p0;
  logic [1:0]   state_nxt;
  logic [W-1:0] skid_p0;
  logic         acc;
  logic         drn;
  logic         load_in;
  logic         load_skid;
  logic         fill_skid;

  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;
  assign out_valid = (state_p0 != ST_EMPTY);

  assign load_in   = acc && ((state_p0 == ST_EMPTY) || ((state_p0 == ST_ONE) && drn));
  assign load_skid = (state_p0 == ST_TWO) && drn;
  assign fill_skid = (state_p0 == ST_ONE) && acc && !drn;

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      ST_EMPTY: if (acc) state_nxt = ST_ONE;
      ST_ONE: begin
        if (acc && !drn)      state_nxt = ST_TWO;
        else if (!acc && drn) state_nxt = ST_EMPTY;
      end
      ST_TWO:   if (drn) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state_p0 <= state_nxt;
      in_ready <= (state_nxt != ST_TWO);
    end
  end

  // Output register is visible on the ports, so it clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            out_data <= '0;
    else if (load_in)   out_data <= in_data;
    else if (load_skid) out_data <= skid_p0;
  end

  always_ff @(posedge clk) begin
    if (fill_skid) skid_p0 <= in_data;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: combinational decode feeding a two-entry skid buffer.
// Build option: IMM_GEN_ZICSR_EN (see imm_gen_pkg) adds CSR*I zimm decoding.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output imm_fmt_t         out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW = XLEN + 3 + 1 + TAG_W;

  imm_dec_t       dec_p0;
  logic [PW-1:0]  pay_p0;
  logic [PW-1:0]  pay_p1;
  logic           imm_unused;

  // Stage 0: decode the incoming instruction
  assign dec_p0     = imm_decode(in_inst, XLEN == 64);
  assign pay_p0     = {dec_p0.imm[XLEN-1:0], dec_p0.fmt, dec_p0.illegal, in_tag};
  assign imm_unused = ^dec_p0.imm;

  imm_skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_p0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_p1)
  );

  // Stage 1: unpack the registered result
  assign out_tag     = pay_p1[TAG_W-1:0];
  assign out_illegal = pay_p1[TAG_W];
  assign out_fmt     = imm_fmt_t'(pay_p1[TAG_W+3:TAG_W+1]);
  assign out_imm     = pay_p1[PW-1:TAG_W+4];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance share one input stream.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        r32, v32, ill32;
  logic [31:0] imm32, tag32;
  imm_fmt_t    fmt32;
  logic        r64, v64, ill64;
  logic [63:0] imm64;
  logic [31:0] tag64;
  imm_fmt_t    fmt64;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r32), .in_inst(in_inst),
    .in_tag(in_tag), .out_valid(v32), .out_ready(out_ready), .out_imm(imm32),
    .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r64), .in_inst(in_inst),
    .in_tag(in_tag), .out_valid(v64), .out_ready(out_ready), .out_imm(imm64),
    .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One instruction presented to an idle pipe; returns just after the accepting edge.
  task automatic xact(input logic [31:0] inst, input logic [31:0] tag);
    in_valid  = 1'b1;
    in_inst   = inst;
    in_tag    = tag;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  task automatic chk_res(input string nm, input logic [63:0] e32, input logic [63:0] e64,
                         input logic [2:0] f32, input logic [2:0] f64,
                         input logic il32, input logic il64, input logic [31:0] tg);
    chk({nm, "_vld"},   {63'b0, v32}, 64'd1);
    chk({nm, "_imm32"}, {32'b0, imm32}, e32);
    chk({nm, "_imm64"}, imm64, e64);
    chk({nm, "_fmt32"}, {61'b0, fmt32}, {61'b0, f32});
    chk({nm, "_fmt64"}, {61'b0, fmt64}, {61'b0, f64});
    chk({nm, "_ill32"}, {63'b0, ill32}, {63'b0, il32});
    chk({nm, "_ill64"}, {63'b0, ill64}, {63'b0, il64});
    chk({nm, "_tag"},   {32'b0, tag32}, {32'b0, tg});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  occ, nin, nout;
    bit  doacc, dodrn, saw_stall;
    logic exp_rdy;
    in_valid = 1'b0; in_inst = '0; in_tag = '0; out_ready = 1'b0;

    // asynchronous reset, checked before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_vld",   {63'b0, v32}, 64'd0);
    chk("rst_rdy",   {63'b0, r32}, 64'd1);
    chk("rst_rdy64", {63'b0, r64}, 64'd1);
    chk("rst_imm",   {32'b0, imm32}, 64'd0);
    chk("rst_fmt",   {61'b0, fmt32}, 64'd0);
    chk("rst_ill",   {63'b0, ill32}, 64'd0);
    chk("rst_tag",   {32'b0, tag32}, 64'd0);
    chk("rst_vld64", {63'b0, v64}, 64'd0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    xact(32'h800000B7, 32'h1000);
    chk_res("lui", 64'h80000000, 64'hFFFFFFFF80000000, 3'd4, 3'd4, 1'b0, 1'b0, 32'h1000);
    xact(32'hFFDFF0EF, 32'h1004);
    chk_res("jal", 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd5, 3'd5, 1'b0, 1'b0, 32'h1004);
    xact(32'h4030D093, 32'h1008);
    chk_res("srai", 64'd3, 64'd3, 3'd6, 3'd6, 1'b0, 1'b0, 32'h1008);
    xact(32'hFFF00093, 32'h100C);
    chk_res("addi", 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1, 1'b0, 1'b0, 32'h100C);
    xact(32'hFE20AC23, 32'h1010);
    chk_res("sw", 64'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd2, 3'd2, 1'b0, 1'b0, 32'h1010);
    xact(32'hFE000CE3, 32'h1014);
    chk_res("beq", 64'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd3, 3'd3, 1'b0, 1'b0, 32'h1014);
    xact(32'h0000007F, 32'h1018);
    chk_res("opc7f", 64'd0, 64'd0, 3'd0, 3'd0, 1'b1, 1'b1, 32'h1018);
    xact(32'h00000000, 32'h101C);
    chk_res("zero", 64'd0, 64'd0, 3'd0, 3'd0, 1'b1, 1'b1, 32'h101C);
    xact(32'h0050009B, 32'h1020);
    chk_res("addiw", 64'd0, 64'd5, 3'd0, 3'd1, 1'b1, 1'b0, 32'h1020);
    xact(32'h00000073, 32'h1024);
    chk_res("ecall", 64'd0, 64'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'h1024);
    xact(32'h300FD073, 32'h1028);
`ifdef IMM_GEN_ZICSR_EN
    chk_res("csrrwi", 64'd31, 64'd31, 3'd7, 3'd7, 1'b0, 1'b0, 32'h1028);
`else
    chk_res("csrrwi", 64'd0, 64'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'h1028);
`endif
    @(posedge clk); #1;
    chk("drain_empty", {63'b0, v32}, 64'd0);

    // 8-instruction stream, consumer stalls for cycles 3..5
    occ = 0; nin = 0; nout = 0; saw_stall = 1'b0;
    for (int cyc = 0; cyc < 40 && nout < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (nin < 8);
      in_inst   = {12'(nin), 20'h00013};
      in_tag    = 32'h100 + nin;
      doacc     = in_valid && r32;
      dodrn     = v32 && out_ready;
      if (dodrn) begin
        chk("stream_imm", {32'b0, imm32}, 64'(nout));
        chk("stream_tag", {32'b0, tag32}, 64'(32'h100 + nout));
        nout++;
      end
      occ     = occ + int'(doacc) - int'(dodrn);
      nin     = nin + int'(doacc);
      exp_rdy = (occ != 2);
      @(posedge clk); #1;
      chk("stream_rdy", {63'b0, r32}, {63'b0, exp_rdy});
      chk("stream_vld", {63'b0, v32}, {63'b0, occ != 0});
      if (!r32) saw_stall = 1'b1;
    end
    in_valid = 1'b0;
    chk("stream_count", 64'(nout), 64'd8);
    chk("stream_stalled", {63'b0, saw_stall}, 64'd1);

    // fill both entries, then reset mid-cycle
    out_ready = 1'b0;
    in_valid  = 1'b1; in_inst = 32'h800000B7; in_tag = 32'hA1;
    @(posedge clk); #1;
    in_inst = 32'hFFDFF0EF; in_tag = 32'hA2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("two_rdy", {63'b0, r32}, 64'd0);
    chk("two_vld", {63'b0, v32}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", {63'b0, v32}, 64'd0);
    chk("arst_rdy", {63'b0, r32}, 64'd1);
    chk("arst_tag", {32'b0, tag32}, 64'd0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("no_stale", {63'b0, v32}, 64'd0);
    xact(32'h4030D093, 32'hB0);
    chk_res("post_rst", 64'd3, 64'd3, 3'd6, 3'd6, 1'b0, 1'b0, 32'hB0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
